// File: rtl/inst_fetch_axi.sv
// inst_fetch_axi: instruction-fetch read engine. It takes one fetch address
// at a time from the next-PC generator and issues it as a single-beat AXI
// read. Returned words are buffered with their PC in a DEPTH-entry FIFO and
// handed to decode through a valid/accept handshake. A flush drops all
// buffered entries and any read that is already in flight.
// Optional build macro: IFETCH_BUSERR_EN adds inst_buserr, which stores
// rresp[1] with each FIFO entry.
module inst_fetch_axi #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [3:0]  ARID_VAL = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        addr_ok,
  input  logic        flush,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        inst_accept
`ifdef IFETCH_BUSERR_EN
  ,
  output logic        inst_buserr
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DROP
  } state_e;

  state_e             state_q, state_d;
  logic               drop_pending_q, drop_pending_d;
  logic [31:0]        araddr_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        pc_mem_q   [DEPTH];
  logic [31:0]        data_mem_q [DEPTH];
  logic               accept;
  logic               push;
  logic               pop;

`ifdef IFETCH_BUSERR_EN
  logic               err_mem_q  [DEPTH];
  logic               unused_inputs;
  assign unused_inputs = ^{rid, rlast, rresp[0]};
`else
  logic               unused_inputs;
  assign unused_inputs = ^{rid, rlast, rresp};
`endif

  // Fixed single-beat, 4-byte, INCR read attributes
  assign arid    = ARID_VAL;
  assign arlen   = '0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign araddr  = araddr_q;

  assign accept = fetch_req && addr_ok;
  // Flush has priority over a push in the same cycle
  assign push   = (state_q == S_R) && rvalid && !flush;
  assign pop    = inst_valid && inst_accept;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      drop_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      drop_pending_q <= drop_pending_d;
    end
  end

  // Next-state logic; ARVALID, once raised, stays up until arready even across a flush
  always_comb begin
    state_d        = state_q;
    drop_pending_d = drop_pending_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_AR;
      end
      S_AR: begin
        if (flush) drop_pending_d = 1'b1;
        if (arready) state_d = (drop_pending_q || flush) ? S_DROP : S_R;
      end
      S_R: begin
        if (rvalid)     state_d = S_IDLE;
        else if (flush) state_d = S_DROP;
      end
      S_DROP: begin
        if (rvalid) begin
          state_d        = S_IDLE;
          drop_pending_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; a flush frees all buffered slots for the redirect target
  always_comb begin
    arvalid = (state_q == S_AR);
    rready  = (state_q == S_R) || (state_q == S_DROP);
    addr_ok = (state_q == S_IDLE) && (flush || (count_q < CNT_W'(DEPTH)));
  end

  // Latch the accepted fetch address; held stable through the read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     araddr_q <= '0;
    else if (accept) araddr_q <= fetch_addr;
  end

  // FIFO pointers and occupancy; flush beats both push and pop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!push && pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // FIFO storage: {pc, instruction} written at the tail
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_mem_q   <= '{default: '0};
      data_mem_q <= '{default: '0};
`ifdef IFETCH_BUSERR_EN
      err_mem_q  <= '{default: 1'b0};
`endif
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= araddr_q;
      data_mem_q[wr_ptr_q] <= rdata;
`ifdef IFETCH_BUSERR_EN
      err_mem_q[wr_ptr_q]  <= rresp[1];
`endif
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign inst_data  = data_mem_q[rd_ptr_q];
`ifdef IFETCH_BUSERR_EN
  assign inst_buserr = err_mem_q[rd_ptr_q];
`endif

  // A slot is reserved at address acceptance, so a push never finds the FIFO full
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_inst_fetch_axi.sv
// tb_inst_fetch_axi: self-checking bench for inst_fetch_axi (DEPTH=2).
// Build with +define+IFETCH_BUSERR_EN to also check inst_buserr.
module tb_inst_fetch_axi;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        addr_ok;
  logic        flush;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_accept;
`ifdef IFETCH_BUSERR_EN
  logic        inst_buserr;
`endif

  inst_fetch_axi #(
    .DEPTH    (2),
    .ARID_VAL (4'd0)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .addr_ok     (addr_ok),
    .flush       (flush),
    .arid        (arid),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .arlock      (arlock),
    .arcache     (arcache),
    .arprot      (arprot),
    .arvalid     (arvalid),
    .arready     (arready),
    .rid         (rid),
    .rdata       (rdata),
    .rresp       (rresp),
    .rlast       (rlast),
    .rvalid      (rvalid),
    .rready      (rready),
    .inst_valid  (inst_valid),
    .inst_pc     (inst_pc),
    .inst_data   (inst_data),
    .inst_accept (inst_accept)
`ifdef IFETCH_BUSERR_EN
    ,
    .inst_buserr (inst_buserr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    int unsigned arw;
    int unsigned rw;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  vec_t vecs [7];
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Compare FIFO head against the oldest expected entry
  task automatic chk_head();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL sb_empty: inst_valid=%0b with no entry expected", inst_valid);
      return;
    end
    e = sb.pop_front();
    chk("inst_valid", 32'(inst_valid), 32'd1);
    chk("inst_pc", inst_pc, e.pc);
    chk("inst_data", inst_data, e.data);
`ifdef IFETCH_BUSERR_EN
    chk("inst_buserr", 32'(inst_buserr), 32'(e.err));
`endif
  endtask

  task automatic request(input logic [31:0] a, input logic fl);
    fetch_req  = 1'b1;
    fetch_addr = a;
    flush      = fl;
    #1;
    chk("req_addr_ok", 32'(addr_ok), 32'd1);
    nxt();
    fetch_req  = 1'b0;
    fetch_addr = '0;
    flush      = 1'b0;
  endtask

  // Slave side of one read; optionally pop the head in the push cycle
  task automatic serve(input vec_t v, input logic pop);
    exp_t e;
    for (int unsigned i = 0; i < v.arw; i++) begin
      #1;
      chk("arvalid_wait", 32'(arvalid), 32'd1);
      chk("araddr_hold", araddr, v.addr);
      nxt();
    end
    arready = 1'b1;
    #1;
    chk("arvalid", 32'(arvalid), 32'd1);
    chk("araddr", araddr, v.addr);
    nxt();
    arready = 1'b0;
    for (int unsigned i = 0; i < v.rw; i++) begin
      #1;
      chk("rready_wait", 32'(rready), 32'd1);
      chk("addr_ok_busy", 32'(addr_ok), 32'd0);
      nxt();
    end
    rvalid      = 1'b1;
    rdata       = v.data;
    rresp       = v.resp;
    inst_accept = pop;
    #1;
    chk("rready", 32'(rready), 32'd1);
    if (pop) chk_head();
    nxt();
    rvalid      = 1'b0;
    rdata       = '0;
    rresp       = '0;
    inst_accept = 1'b0;
    e.pc   = v.addr;
    e.data = v.data;
    e.err  = v.exp_err;
    sb.push_back(e);
  endtask

  task automatic do_fetch(input vec_t v, input logic pop);
    request(v.addr, 1'b0);
    serve(v, pop);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t;
    exp_t e;
    vecs[0] = '{32'hbfc0_0100, 32'h2408_0005, 2'b00, 0, 0, 1'b0};
    vecs[1] = '{32'hbfc0_0104, 32'h2409_0006, 2'b00, 1, 0, 1'b0};
    vecs[2] = '{32'hbfc0_0108, 32'h8d0a_0000, 2'b10, 0, 2, 1'b1};
    vecs[3] = '{32'hbfc0_010c, 32'h014b_6021, 2'b00, 2, 1, 1'b0};
    vecs[4] = '{32'hbfc0_0110, 32'h1000_ffff, 2'b01, 0, 0, 1'b0};
    vecs[5] = '{32'hbfc0_0114, 32'h0000_0000, 2'b00, 3, 3, 1'b0};
    vecs[6] = '{32'hbfc0_0118, 32'hffff_ffff, 2'b00, 1, 1, 1'b0};

    resetn = 1'b0; fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1;
    rvalid = 1'b0; inst_accept = 1'b0;

    // Reset state and fixed AR attributes
    #12;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_addr_ok", 32'(addr_ok), 32'd1);
    chk("arid", 32'(arid), 32'd0);
    chk("arlen", 32'(arlen), 32'd0);
    chk("arsize", 32'(arsize), 32'd2);
    chk("arburst", 32'(arburst), 32'd1);
    chk("ar_misc", 32'({arlock, arcache, arprot}), 32'd0);
    nxt();
    resetn = 1'b1;
    nxt();

    // Single fetch with immediate arready / rvalid: N, N+1 AR, N+2 R, N+3 valid
    fetch_req = 1'b1; fetch_addr = 32'hbfc0_0000;
    #1;
    chk("t1_addr_ok", 32'(addr_ok), 32'd1);
    chk("t1_arvalid_n", 32'(arvalid), 32'd0);
    nxt();
    fetch_req = 1'b0; fetch_addr = '0; arready = 1'b1;
    #1;
    chk("t1_arvalid_n1", 32'(arvalid), 32'd1);
    chk("t1_araddr", araddr, 32'hbfc0_0000);
    chk("t1_addr_ok_busy", 32'(addr_ok), 32'd0);
    nxt();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h3c08_0001;
    #1;
    chk("t1_arvalid_n2", 32'(arvalid), 32'd0);
    chk("t1_rready_n2", 32'(rready), 32'd1);
    chk("t1_valid_n2", 32'(inst_valid), 32'd0);
    e.pc = 32'hbfc0_0000; e.data = 32'h3c08_0001; e.err = 1'b0;
    sb.push_back(e);
    nxt();
    rvalid = 1'b0; rdata = '0;
    inst_accept = 1'b1;
    chk_head();
    nxt();
    inst_accept = 1'b0;
    chk("t1_drained", 32'(inst_valid), 32'd0);

    // Back-to-back fetches fill DEPTH=2; addr_ok drops until a pop
    t = '{32'h8000_0200, 32'h1111_1111, 2'b00, 0, 0, 1'b0};
    do_fetch(t, 1'b0);
    t = '{32'h8000_0204, 32'h2222_2222, 2'b00, 1, 1, 1'b0};
    do_fetch(t, 1'b0);
    fetch_req = 1'b1; fetch_addr = 32'h8000_0208;
    #1;
    chk("full_addr_ok", 32'(addr_ok), 32'd0);
    nxt();
    chk("full_no_ar", 32'(arvalid), 32'd0);
    chk("full_addr_ok2", 32'(addr_ok), 32'd0);
    inst_accept = 1'b1;
    chk_head();
    fetch_req = 1'b0;
    nxt();
    inst_accept = 1'b0;
    chk("pop_addr_ok", 32'(addr_ok), 32'd1);
    chk("pop_one_left", 32'(inst_valid), 32'd1);
    t = '{32'h8000_0208, 32'h3333_3333, 2'b00, 0, 0, 1'b0};
    do_fetch(t, 1'b0);

    // Flush in IDLE with 2 buffered: cleared, redirect target accepted
    request(32'hbfc0_0380, 1'b1);
    chk("flush_empty", 32'(inst_valid), 32'd0);
    sb.delete();
    t = '{32'hbfc0_0380, 32'h4000_6800, 2'b00, 0, 0, 1'b0};
    serve(t, 1'b0);
    inst_accept = 1'b1;
    chk_head();
    nxt();
    inst_accept = 1'b0;
    chk("redir_drained", 32'(inst_valid), 32'd0);

    // Flush while in AR, arready delayed 3 cycles: read is dropped
    request(32'h9000_0000, 1'b0);
    flush = 1'b1;
    #1;
    chk("drop_arvalid1", 32'(arvalid), 32'd1);
    nxt();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drop_arvalid_hold", 32'(arvalid), 32'd1);
      chk("drop_araddr_hold", araddr, 32'h9000_0000);
      chk("drop_addr_ok_ar", 32'(addr_ok), 32'd0);
      nxt();
    end
    arready = 1'b1;
    #1;
    chk("drop_arvalid4", 32'(arvalid), 32'd1);
    nxt();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drop_rready", 32'(rready), 32'd1);
      chk("drop_addr_ok", 32'(addr_ok), 32'd0);
      chk("drop_valid", 32'(inst_valid), 32'd0);
      nxt();
    end
    rvalid = 1'b1; rdata = 32'hdead_beef;
    #1;
    chk("drop_addr_ok_rv", 32'(addr_ok), 32'd0);
    nxt();
    rvalid = 1'b0; rdata = '0;
    #1;
    chk("drop_discarded", 32'(inst_valid), 32'd0);
    chk("drop_idle_addr_ok", 32'(addr_ok), 32'd1);
    chk("drop_idle_rready", 32'(rready), 32'd0);
    nxt();

    // Table: push and pop together at count=1, order kept across pointer wrap
    do_fetch(vecs[0], 1'b0);
    for (int k = 1; k < 7; k++) begin
      do_fetch(vecs[k], 1'b1);
      chk("pp_count1", 32'(inst_valid), 32'd1);
    end
    inst_accept = 1'b1;
    chk_head();
    nxt();
    inst_accept = 1'b0;
    chk("pp_drained", 32'(inst_valid), 32'd0);

    // Async reset in R state with one entry buffered
    t = '{32'ha000_0040, 32'h5555_aaaa, 2'b00, 0, 0, 1'b0};
    do_fetch(t, 1'b0);
    request(32'ha000_0044, 1'b0);
    arready = 1'b1;
    nxt();
    arready = 1'b0;
    chk("mr_rready", 32'(rready), 32'd1);
    chk("mr_valid", 32'(inst_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mr_rst_rready", 32'(rready), 32'd0);
    chk("mr_rst_arvalid", 32'(arvalid), 32'd0);
    chk("mr_rst_araddr", araddr, 32'd0);
    chk("mr_rst_valid", 32'(inst_valid), 32'd0);
    chk("mr_rst_pc", inst_pc, 32'd0);
    chk("mr_rst_data", inst_data, 32'd0);
    nxt();
    resetn = 1'b1;
    sb.delete();
    t = '{32'ha000_0100, 32'h0c00_0010, 2'b00, 1, 1, 1'b0};
    do_fetch(t, 1'b0);
    inst_accept = 1'b1;
    chk_head();
    nxt();
    inst_accept = 1'b0;

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
